// File: rtl/pkt_buf_pkg.sv
// Shared definitions for the packet buffer: FSM encoding, ctrl constants and EOP detection.
package pkt_buf_pkg;

    typedef enum logic [1:0] {
        ST_RECV = 2'd0,
        ST_PROC = 2'd1,
        ST_SEND = 2'd2,
        ST_DROP = 2'd3
    } state_e;

    localparam logic [7:0] CTRL_SOP  = 8'hFF;
    localparam logic [7:0] CTRL_EOP  = 8'h01;
    localparam logic [7:0] CTRL_BODY = 8'h00;

    // The packet ends on the first nonzero ctrl that follows a zero ctrl.
    function automatic logic is_eop(input logic prev_ctrl_zero, input logic ctrl_nonzero);
        return prev_ctrl_zero & ctrl_nonzero;
    endfunction

endpackage

// File: rtl/pkt_buf_ram.sv
// Dual-port synchronous RAM: port A ingress writes, port B core/egress read-write.
module pkt_buf_ram #(
    parameter int WIDTH      = 72,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  a_we_i,
    input  logic [ADDR_WIDTH-1:0] a_addr_i,
    input  logic [WIDTH-1:0]      a_wdata_i,
    input  logic                  b_en_i,
    input  logic                  b_we_i,
    input  logic [ADDR_WIDTH-1:0] b_addr_i,
    input  logic [WIDTH-1:0]      b_wdata_i,
    output logic [WIDTH-1:0]      b_rdata_o
);

    logic [WIDTH-1:0] mem_q [2**ADDR_WIDTH];

    always_ff @(posedge clk_i) begin
        if (a_we_i) mem_q[a_addr_i] <= a_wdata_i;
        if (b_we_i) mem_q[b_addr_i] <= b_wdata_i;
    end

    // Read register is reset so egress and core read data come up as zero.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            b_rdata_o <= '0;
        end else if (b_en_i) begin
            b_rdata_o <= mem_q[b_addr_i];
        end
    end

endmodule

// File: rtl/pkt_buf_sram.sv
// Store-process-forward packet buffer over a circular SRAM.
// Optional statistics counters are built when PKT_BUF_STATS_EN is defined.
module pkt_buf_sram
    import pkt_buf_pkg::*;
#(
    parameter int DATA_WIDTH     = 64,
    parameter int CTRL_WIDTH     = 8,
    parameter int ADDR_WIDTH     = 10,
    parameter int ALMFULL_MARGIN = 4
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [DATA_WIDTH-1:0]            in_data,
    input  logic [CTRL_WIDTH-1:0]            in_ctrl,
    input  logic                             in_wr,
    output logic                             in_rdy,
    output logic [DATA_WIDTH-1:0]            out_data,
    output logic [CTRL_WIDTH-1:0]            out_ctrl,
    output logic                             out_wr,
    input  logic                             out_rdy,
    input  logic [ADDR_WIDTH-1:0]            proc_addr,
    input  logic [CTRL_WIDTH+DATA_WIDTH-1:0] proc_wdata,
    input  logic                             proc_we,
    output logic [CTRL_WIDTH+DATA_WIDTH-1:0] proc_rdata,
    output logic                             proc_start,
    input  logic                             proc_done,
    input  logic                             proc_drop,
    output logic [ADDR_WIDTH-1:0]            pkt_len,
    output logic                             trunc
`ifdef PKT_BUF_STATS_EN
    ,
    output logic [31:0]                      pkt_fwd_cnt,
    output logic [31:0]                      pkt_drop_cnt,
    output logic [31:0]                      pkt_trunc_cnt
`endif
);

    localparam int                    DEPTH = 2**ADDR_WIDTH;
    localparam int                    RAM_W = CTRL_WIDTH + DATA_WIDTH;
    localparam logic [ADDR_WIDTH:0]   LIMIT = (ADDR_WIDTH+1)'(DEPTH - ALMFULL_MARGIN);
    localparam logic [ADDR_WIDTH-1:0] A_ONE = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH:0]   W_ONE = (ADDR_WIDTH+1)'(1);

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH-1:0] base_q, base_d;
    logic [ADDR_WIDTH-1:0] len_q, len_d;
    logic                  trunc_q, trunc_d;
    logic                  prev_zero_q, prev_zero_d;
    logic                  start_q, start_d;
    logic                  out_wr_q, out_wr_d;

    logic                  accept, eop, enter_proc, more, fetch;
    logic [ADDR_WIDTH-1:0] fetched;
    logic                  b_en, b_we;
    logic [ADDR_WIDTH-1:0] b_addr;
    logic [RAM_W-1:0]      b_rdata;

    assign in_rdy = (state_q == ST_RECV) && !trunc_q && ({1'b0, len_q} < LIMIT);

    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        base_d      = base_q;
        len_d       = len_q;
        trunc_d     = trunc_q;
        prev_zero_d = prev_zero_q;
        out_wr_d    = out_wr_q;
        accept      = 1'b0;
        enter_proc  = 1'b0;
        fetch       = 1'b0;
        eop         = is_eop(prev_zero_q, |in_ctrl);
        fetched     = rd_ptr_q - base_q;
        more        = (fetched != len_q);

        case (state_q)
            ST_RECV: begin
                // While truncating, words are still watched so the EOP is found.
                if (in_wr && (in_rdy || trunc_q)) begin
                    prev_zero_d = ~|in_ctrl;
                    if (in_rdy) begin
                        accept   = 1'b1;
                        wr_ptr_d = wr_ptr_q + A_ONE;
                        len_d    = len_q + A_ONE;
                        if (!eop && (({1'b0, len_q} + W_ONE) == LIMIT)) trunc_d = 1'b1;
                    end
                    if (eop) begin
                        enter_proc  = 1'b1;
                        prev_zero_d = 1'b0;
                        state_d     = ST_PROC;
                    end
                end
            end
            ST_PROC: begin
                if (proc_drop)      state_d = ST_DROP;
                else if (proc_done) state_d = ST_SEND;
            end
            ST_SEND: begin
                // Output register and RAM read register advance together on out_rdy.
                if (out_rdy) begin
                    out_wr_d = more;
                    if (more) begin
                        fetch    = 1'b1;
                        rd_ptr_d = rd_ptr_q + A_ONE;
                    end
                end
                if (!more && (!out_wr_q || out_rdy)) begin
                    out_wr_d = 1'b0;
                    base_d   = wr_ptr_q;
                    rd_ptr_d = wr_ptr_q;
                    len_d    = '0;
                    trunc_d  = 1'b0;
                    state_d  = ST_RECV;
                end
            end
            default: begin
                base_d   = wr_ptr_q;
                rd_ptr_d = wr_ptr_q;
                len_d    = '0;
                trunc_d  = 1'b0;
                state_d  = ST_RECV;
            end
        endcase

        start_d = enter_proc;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_RECV;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            base_q      <= '0;
            len_q       <= '0;
            trunc_q     <= 1'b0;
            prev_zero_q <= 1'b0;
            start_q     <= 1'b0;
            out_wr_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            base_q      <= base_d;
            len_q       <= len_d;
            trunc_q     <= trunc_d;
            prev_zero_q <= prev_zero_d;
            start_q     <= start_d;
            out_wr_q    <= out_wr_d;
        end
    end

    assign b_addr = (state_q == ST_SEND) ? rd_ptr_q : (base_q + proc_addr);
    assign b_en   = (state_q == ST_PROC) || fetch;
    assign b_we   = (state_q == ST_PROC) && proc_we;

    pkt_buf_ram #(
        .WIDTH      (RAM_W),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .clk_i     (clk),
        .rst_i     (reset),
        .a_we_i    (accept),
        .a_addr_i  (wr_ptr_q),
        .a_wdata_i ({in_ctrl, in_data}),
        .b_en_i    (b_en),
        .b_we_i    (b_we),
        .b_addr_i  (b_addr),
        .b_wdata_i (proc_wdata),
        .b_rdata_o (b_rdata)
    );

    assign out_data   = b_rdata[DATA_WIDTH-1:0];
    assign out_ctrl   = b_rdata[RAM_W-1:DATA_WIDTH];
    assign out_wr     = out_wr_q;
    assign proc_rdata = b_rdata;
    assign proc_start = start_q;
    assign pkt_len    = len_q;
    assign trunc      = trunc_q;

`ifdef PKT_BUF_STATS_EN
    logic [31:0] fwd_cnt_q, drop_cnt_q, trunc_cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fwd_cnt_q   <= '0;
            drop_cnt_q  <= '0;
            trunc_cnt_q <= '0;
        end else begin
            if (state_q == ST_SEND && state_d == ST_RECV && fwd_cnt_q != '1)
                fwd_cnt_q <= fwd_cnt_q + 32'd1;
            if (state_q == ST_DROP && drop_cnt_q != '1)
                drop_cnt_q <= drop_cnt_q + 32'd1;
            if (enter_proc && trunc_q && trunc_cnt_q != '1)
                trunc_cnt_q <= trunc_cnt_q + 32'd1;
        end
    end

    assign pkt_fwd_cnt   = fwd_cnt_q;
    assign pkt_drop_cnt  = drop_cnt_q;
    assign pkt_trunc_cnt = trunc_cnt_q;
`endif

endmodule

// File: tb/tb_pkt_buf_sram.sv
// Directed bench for pkt_buf_sram (depth 16, margin 2) with an egress scoreboard.
module tb_pkt_buf_sram;
    import pkt_buf_pkg::*;

    localparam int DW = 64;
    localparam int CW = 8;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [DW-1:0] in_data = '0;
    logic [CW-1:0] in_ctrl = '0;
    logic          in_wr = 1'b0;
    logic          in_rdy;
    logic [DW-1:0] out_data;
    logic [CW-1:0] out_ctrl;
    logic          out_wr;
    logic          out_rdy = 1'b1;
    logic [AW-1:0] proc_addr = '0;
    logic [CW+DW-1:0] proc_wdata = '0;
    logic          proc_we = 1'b0;
    logic [CW+DW-1:0] proc_rdata;
    logic          proc_start;
    logic          proc_done = 1'b0;
    logic          proc_drop = 1'b0;
    logic [AW-1:0] pkt_len;
    logic          trunc;

    int checks = 0;
    int errors = 0;
    int wr_cycles = 0;
    logic [CW+DW-1:0] exp_q[$];

    pkt_buf_sram #(
        .DATA_WIDTH(DW), .CTRL_WIDTH(CW), .ADDR_WIDTH(AW), .ALMFULL_MARGIN(2)
    ) dut (
        .clk(clk), .reset(reset),
        .in_data(in_data), .in_ctrl(in_ctrl), .in_wr(in_wr), .in_rdy(in_rdy),
        .out_data(out_data), .out_ctrl(out_ctrl), .out_wr(out_wr), .out_rdy(out_rdy),
        .proc_addr(proc_addr), .proc_wdata(proc_wdata), .proc_we(proc_we),
        .proc_rdata(proc_rdata), .proc_start(proc_start),
        .proc_done(proc_done), .proc_drop(proc_drop),
        .pkt_len(pkt_len), .trunc(trunc)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_pkt(input int n, input logic [DW-1:0] dbase, input bit push);
        for (int i = 0; i < n; i++) begin
            in_ctrl = (i == 0) ? CTRL_SOP : ((i == n-1) ? CTRL_EOP : CTRL_BODY);
            in_data = dbase + DW'(i);
            in_wr   = 1'b1;
            if (push) exp_q.push_back({in_ctrl, in_data});
            tick();
        end
        in_wr   = 1'b0;
        in_ctrl = '0;
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        out_rdy   = 1'b1;
        proc_done = 1'b1;
        tick();
        proc_done = 1'b0;
        while (!in_rdy && n < 100) begin
            tick();
            n++;
        end
        check({tag, "_back_to_recv"}, in_rdy, 1);
        check({tag, "_queue_empty"}, exp_q.size(), 0);
    endtask

    // Egress monitor: a word is consumed on the edge after out_wr & out_rdy.
    always @(negedge clk) begin
        if (!reset && out_wr) wr_cycles++;
        if (!reset && out_wr && out_rdy) begin
            if (exp_q.size() == 0) check("egress_extra_word", out_wr, 0);
            else check("egress_word", {out_ctrl, out_data}, exp_q.pop_front());
        end
    end

    initial begin
        int pat[4];
        logic held;
        pat = '{1, 0, 0, 1};

        // 1: reset values, then a 5-word packet
        repeat (2) tick();
        check("rst_in_rdy", in_rdy, 1);
        check("rst_out_wr", out_wr, 0);
        check("rst_proc_start", proc_start, 0);
        check("rst_trunc", trunc, 0);
        check("rst_pkt_len", pkt_len, 0);
        check("rst_out_data", {out_ctrl, out_data}, 0);
        check("rst_proc_rdata", proc_rdata, 0);
        reset = 1'b0;
        tick();
        send_pkt(5, 64'h1000, 1'b1);
        check("t1_proc_start", proc_start, 1);
        check("t1_pkt_len", pkt_len, 5);
        check("t1_in_rdy_low", in_rdy, 0);
        tick();
        check("t1_start_pulse_end", proc_start, 0);

        // 2: core read, write, readback, forward
        proc_addr = 4'd1;
        tick();
        check("t2_read_off1", proc_rdata, {8'h00, 64'h1001});
        proc_we    = 1'b1;
        proc_wdata = {8'h00, 64'hA5};
        tick();
        proc_we = 1'b0;
        tick();
        check("t2_readback_off1", proc_rdata, {8'h00, 64'hA5});
        exp_q[1] = {8'h00, 64'hA5};
        wr_cycles = 0;
        drain("t2");
        check("t2_out_wr_cycles", wr_cycles, 5);

        // 3: egress back-pressure pattern 1,0,0,1
        send_pkt(4, 64'h2000, 1'b1);
        proc_done = 1'b1;
        tick();
        proc_done = 1'b0;
        for (int i = 0; i < 60 && !in_rdy; i++) begin
            out_rdy = pat[i % 4][0];
            held    = out_wr && !out_rdy;
            tick();
            if (held && exp_q.size() != 0)
                check("t3_hold", {out_wr, out_ctrl, out_data}, {1'b1, exp_q[0]});
        end
        check("t3_back_to_recv", in_rdy, 1);
        check("t3_queue_empty", exp_q.size(), 0);
        out_rdy = 1'b1;

        // 4: drop and done together, drop wins
        send_pkt(3, 64'h3000, 1'b0);
        wr_cycles = 0;
        proc_drop = 1'b1;
        proc_done = 1'b1;
        tick();
        proc_drop = 1'b0;
        proc_done = 1'b0;
        check("t4_in_rdy_drop_cycle", in_rdy, 0);
        tick();
        check("t4_in_rdy_after_2", in_rdy, 1);
        check("t4_pkt_len", pkt_len, 0);
        tick();
        check("t4_no_out_wr", wr_cycles, 0);

        // 5: 20-word packet overflows at 14 words; also wraps the pointer
        for (int i = 0; i < 20; i++) begin
            if (i == 13) check("t5_in_rdy_at_13", in_rdy, 1);
            if (i == 14) check("t5_in_rdy_at_14", in_rdy, 0);
            in_ctrl = (i == 0) ? CTRL_SOP : ((i == 19) ? CTRL_EOP : CTRL_BODY);
            in_data = 64'h5000 + 64'(i);
            in_wr   = 1'b1;
            if (i < 14) exp_q.push_back({in_ctrl, in_data});
            tick();
        end
        in_wr   = 1'b0;
        in_ctrl = '0;
        check("t5_proc_start", proc_start, 1);
        check("t5_trunc", trunc, 1);
        check("t5_pkt_len", pkt_len, 14);
        proc_addr = 4'd0;
        tick();
        check("t5_base_after_drop", proc_rdata, {8'hFF, 64'h5000});
        drain("t5");
        check("t5_trunc_cleared", trunc, 0);
        check("t5_len_cleared", pkt_len, 0);

        // 6: wrapping packet, reset during SEND, then recovery
        send_pkt(8, 64'h6000, 1'b1);
        proc_done = 1'b1;
        tick();
        proc_done = 1'b0;
        repeat (3) tick();
        check("t6_mid_send_out_wr", out_wr, 1);
        reset = 1'b1;
        #1;
        check("t6_rst_out_wr", out_wr, 0);
        check("t6_rst_out_data", {out_ctrl, out_data}, 0);
        check("t6_rst_in_rdy", in_rdy, 1);
        check("t6_rst_pkt_len", pkt_len, 0);
        check("t6_rst_proc_rdata", proc_rdata, 0);
        exp_q.delete();
        tick();
        reset = 1'b0;
        tick();
        send_pkt(3, 64'h7000, 1'b1);
        check("t6_recover_start", proc_start, 1);
        drain("t6");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
